// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
// branch_predict_unit : ID-stage branch resolution with a 2-bit counter BHT
// Revision: 1.0
// ============================================================================
module branch_predict_unit #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int STAT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   if_pc,
  output logic              if_pred_taken,
  input  logic              id_valid,
  input  logic              id_stall,
  input  logic [5:0]        id_opcode,
  input  logic [4:0]        id_rt,
  input  logic [PC_W-1:0]   id_pc,
  input  logic              id_pred_taken,
  input  logic [DATA_W-1:0] id_data1,
  input  logic [DATA_W-1:0] id_data2,
  output logic              id_taken,
  output logic              id_mispredict,
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] mispredict_count
);

  localparam int         IDX        = $clog2(BHT_DEPTH);
  localparam logic [1:0] WEAK_NT    = 2'b01;
  localparam logic [1:0] STRONG_T   = 2'b11;
  localparam logic [1:0] STRONG_NT  = 2'b00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;

  logic [1:0]     bht [BHT_DEPTH];
  logic [IDX-1:0] if_idx;
  logic [IDX-1:0] id_idx;
  logic [1:0]     upd_ctr;
  logic           is_regimm;
  logic           supported;
  logic           cond;
  logic           commit;
  logic           d1_neg;
  logic           d1_zero;
  logic           unused_pc_bits;

  // Word-aligned PCs: the two low bits never select an entry.
  assign if_idx  = if_pc[IDX+1:2];
  assign id_idx  = id_pc[IDX+1:2];
  assign upd_ctr = bht[id_idx];

  assign unused_pc_bits = ^{if_pc, id_pc};

  // Lookup sees the pre-edge table; no same-cycle bypass from ID.
  assign if_pred_taken = bht[if_idx][1];

  assign d1_neg  = id_data1[DATA_W-1];
  assign d1_zero = (id_data1 == '0);

  always_comb begin
    is_regimm = (id_opcode == OP_REGIMM) && ((id_rt == 5'd0) || (id_rt == 5'd1));
    supported = id_valid && ((id_opcode == OP_BEQ)  || (id_opcode == OP_BNE) ||
                             (id_opcode == OP_BLEZ) || (id_opcode == OP_BGTZ) ||
                             is_regimm);
    cond = 1'b0;
    case (id_opcode)
      OP_BEQ:    cond = (id_data1 == id_data2);
      OP_BNE:    cond = (id_data1 != id_data2);
      OP_BLEZ:   cond = d1_neg | d1_zero;
      OP_BGTZ:   cond = ~d1_neg & ~d1_zero;
      OP_REGIMM: cond = id_rt[0] ? ~d1_neg : d1_neg;
      default:   cond = 1'b0;
    endcase
  end

  assign id_taken      = supported & cond;
  assign id_mispredict = supported & (cond != id_pred_taken);
  assign commit        = supported & ~id_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= WEAK_NT;
      end
    end else if (commit) begin
      if (id_taken && (upd_ctr != STRONG_T)) begin
        bht[id_idx] <= upd_ctr + 2'd1;
      end else if (!id_taken && (upd_ctr != STRONG_NT)) begin
        bht[id_idx] <= upd_ctr - 2'd1;
      end
    end
  end

  // Statistics stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (commit) begin
      if (branch_count != '1) begin
        branch_count <= branch_count + 1'b1;
      end
      if (id_mispredict && (mispredict_count != '1)) begin
        mispredict_count <= mispredict_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
